bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares a single unified memory port between the core's three bus masters: the instruction read bus, the data read bus and the data write bus. It sits between the core-side bus interfaces and the memory/interconnect and runs one outstanding transaction at a time. Instruction and data traffic are arbitrated round-robin. Within data traffic, a pending write always goes before a pending read so store-to-load ordering holds.

## Interface
- XLEN, 32: data/address width; must be 32 or 64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr_re  in  1  instruction read request, held until instr_ack.
- instr_sel  in  XLEN/8  byte select.
- instr_addr  in  XLEN  instruction address.
- instr_ack  out  1  one-cycle completion strobe.
- instr_data  out  32  read data; equals mem_rdata[31:0].
- dr_re  in  1  data read request, held until dr_ack.
- dr_sel  in  XLEN/8  byte select.
- dr_addr  in  XLEN  data read address.
- dr_ack  out  1  one-cycle completion strobe.
- dr_data  out  XLEN  read data; equals mem_rdata.
- dw_we  in  1  data write request, held until dw_ack.
- dw_sel  in  XLEN/8  byte select.
- dw_addr  in  XLEN  data write address.
- dw_data  in  XLEN  write data.
- dw_ack  out  1  one-cycle completion strobe.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe; never asserted together with mem_re.
- mem_sel  out  XLEN/8  byte select.
- mem_addr  out  XLEN  address.
- mem_wdata  out  XLEN  write data.
- mem_ack  in  1  memory completion; valid only while mem_re or mem_we is high.
- mem_rdata  in  XLEN  read data, valid when mem_ack is high.

## Operation
- The FSM has two states: IDLE and BUSY. The owner register is 2 bits, encoding INSTR, DR or DW. The rr register is 1 bit and names the class that was last served: 0 means instruction, 1 means data.
- IDLE: all requests are sampled.
  - The data candidate is DW if dw_we is high, otherwise DR if dr_re is high.
  - If the instruction request and a data candidate are both present, the class not named by rr wins.
  - If only one class is requesting, that class wins.
  - On a grant: latch owner; register mem_addr, mem_sel and mem_wdata from the winner; set mem_re (INSTR/DR) or mem_we (DW); update rr; go to BUSY.
- BUSY: mem_* outputs are held constant. Master request changes are ignored.
  - On mem_ack, pass it combinationally to the owner's ack output in the same cycle.
  - dr_data and instr_data are driven from mem_rdata at all times; they are meaningful only while the matching ack is high.
  - On the next edge, clear mem_re/mem_we and return to IDLE.
- Non-owner acks are always 0. A mem_ack received in IDLE is ignored and produces no ack.
- Master contract: a master holds its request and its fields stable until ack. By the edge following ack, it either drops the request or presents its next request. The IDLE cycle after an ack therefore sees the updated requests, and no transfer is issued twice.
- Reset, at any time including mid-transaction: state goes to IDLE, rr=1 so instruction wins the first tie, owner=INSTR. The pending transaction is abandoned.

## Timing
- Reset values: mem_re=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, and all acks=0.
- Grant latency is 1 cycle. A request seen in IDLE at cycle t produces mem_re/mem_we at t+1.
- With a combinational-ack memory (mem_ack at t+1), the master's ack arrives at t+1, mem strobes drop at t+2, and the next grant is issued at t+2 with strobes at t+3.
- Peak throughput is one transfer per 2 cycles. Each additional memory wait cycle adds 1 cycle.
- Under continuous instruction and data demand, grants alternate INSTR, data, INSTR, data. No class waits more than one transaction behind the other.
- A data read waiting behind a stream of writes can be delayed indefinitely. The core's store buffer depth bounds this.

## Test plan
- Reset, then instr_re=1 with addr=0x100 and a zero-wait memory → mem_re=1 and mem_addr=0x100 at cycle 1; instr_ack=1 with instr_data=mem_rdata[31:0] at cycle 1; mem_re=0 at cycle 2.
- instr_re and dr_re both held continuously with zero-wait memory → granted owners follow the sequence INSTR, DR, INSTR, DR at cycles 1, 3, 5, 7.
- dw_we (addr 0x40, data 0xDEADBEEF, sel 0xF) and dr_re (addr 0x40) raised together → write completes first, then the read. mem_we and mem_re are never high in the same cycle.
- Memory with 3 wait cycles, dr_re asserted → mem_re held for 4 cycles with constant address; dr_ack high for exactly 1 cycle; instr_ack and dw_ack stay 0 throughout.
- reset pulsed while BUSY and mem_ack arrives the cycle after → next cycle all mem_* outputs and acks are 0; the late mem_ack produces no ack; the first post-reset tie is granted to INSTR.
- Stray mem_ack=1 while IDLE with no requests → all acks remain 0 and the state stays IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory port between the instruction read bus, the
// data read bus and the data write bus. One transaction is in flight at a
// time. Instruction and data classes alternate round-robin. Within data
// traffic a pending write is always taken before a pending read, which keeps
// stores ahead of later loads.
module bus_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              instr_re,
    input  logic [XLEN/8-1:0] instr_sel,
    input  logic [XLEN-1:0]   instr_addr,
    output logic              instr_ack,
    output logic [31:0]       instr_data,

    input  logic              dr_re,
    input  logic [XLEN/8-1:0] dr_sel,
    input  logic [XLEN-1:0]   dr_addr,
    output logic              dr_ack,
    output logic [XLEN-1:0]   dr_data,

    input  logic              dw_we,
    input  logic [XLEN/8-1:0] dw_sel,
    input  logic [XLEN-1:0]   dw_addr,
    input  logic [XLEN-1:0]   dw_data,
    output logic              dw_ack,

    output logic              mem_re,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_sel,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int SW = XLEN / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_INSTR = 2'd0,
        OWN_DR    = 2'd1,
        OWN_DW    = 2'd2
    } owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            rr_q, rr_d;            // last class served: 0 instr, 1 data
    logic            mem_re_q, mem_re_d;
    logic            mem_we_q, mem_we_d;
    logic [SW-1:0]   mem_sel_q, mem_sel_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            data_req_s;
    logic            pick_instr_s;

    assign data_req_s   = dw_we | dr_re;
    // Instruction wins when it is alone, or on a tie when data went last.
    assign pick_instr_s = instr_re & (~data_req_s | rr_q);

    // Arbitration and next-state selection for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (instr_re || data_req_s) begin
                    state_d = BUSY;
                    if (pick_instr_s) begin
                        owner_d     = OWN_INSTR;
                        rr_d        = 1'b0;
                        mem_re_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_sel_d   = instr_sel;
                        mem_addr_d  = instr_addr;
                        mem_wdata_d = {XLEN{1'b0}};
                    end else if (dw_we) begin
                        owner_d     = OWN_DW;
                        rr_d        = 1'b1;
                        mem_re_d    = 1'b0;
                        mem_we_d    = 1'b1;
                        mem_sel_d   = dw_sel;
                        mem_addr_d  = dw_addr;
                        mem_wdata_d = dw_data;
                    end else begin
                        owner_d     = OWN_DR;
                        rr_d        = 1'b1;
                        mem_re_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_sel_d   = dr_sel;
                        mem_addr_d  = dr_addr;
                        mem_wdata_d = {XLEN{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d  = IDLE;
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // FSM state, owner, round-robin pointer and registered memory outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_INSTR;
            rr_q        <= 1'b1;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= {SW{1'b0}};
            mem_addr_q  <= {XLEN{1'b0}};
            mem_wdata_q <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Route the memory completion to the current owner only, and only in BUSY.
    always_comb begin
        instr_ack = 1'b0;
        dr_ack    = 1'b0;
        dw_ack    = 1'b0;
        if ((state_q == BUSY) && mem_ack) begin
            case (owner_q)
                OWN_INSTR: instr_ack = 1'b1;
                OWN_DR:    dr_ack    = 1'b1;
                OWN_DW:    dw_ack    = 1'b1;
                default:   instr_ack = 1'b0;
            endcase
        end else begin
            instr_ack = 1'b0;
        end
    end

    assign instr_data = mem_rdata[31:0];
    assign dr_data    = mem_rdata;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_sel    = mem_sel_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter with a small wait-state memory model.
module tb_bus_arbiter;

    localparam int XLEN = 32;
    localparam logic [31:0] PAT = 32'hA5A5_5A5A;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_re;
    logic [3:0]        instr_sel;
    logic [31:0]       instr_addr;
    logic              instr_ack;
    logic [31:0]       instr_data;
    logic              dr_re;
    logic [3:0]        dr_sel;
    logic [31:0]       dr_addr;
    logic              dr_ack;
    logic [31:0]       dr_data;
    logic              dw_we;
    logic [3:0]        dw_sel;
    logic [31:0]       dw_addr;
    logic [31:0]       dw_data;
    logic              dw_ack;
    logic              mem_re;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    int   vec = 0;
    int   err = 0;
    int   overlap = 0;
    int   waits = 0;
    int   cnt = 0;
    logic ack_block = 1'b0;
    logic stray_ack = 1'b0;

    bus_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr),
        .dr_ack(dr_ack), .dr_data(dr_data),
        .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data),
        .dw_ack(dw_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: acks after 'waits' extra cycles of a held strobe.
    always @(posedge clk) begin
        if (mem_re || mem_we) cnt <= cnt + 1;
        else                  cnt <= 0;
    end
    assign mem_ack   = stray_ack | (~ack_block & (mem_re | mem_we) & (cnt == waits));
    assign mem_rdata = mem_addr ^ PAT;

    // Both strobes high together is never legal.
    always @(negedge clk) begin
        if (mem_re && mem_we) overlap <= overlap + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_re = 1'b0; instr_sel = 4'h0; instr_addr = 32'h0;
        dr_re = 1'b0; dr_sel = 4'h0; dr_addr = 32'h0;
        dw_we = 1'b0; dw_sel = 4'h0; dw_addr = 32'h0; dw_data = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        tick();
        vec++; if (mem_re !== 1'b0) begin err++; $display("FAIL reset_mem_re got %b exp 0", mem_re); end
        vec++; if (mem_we !== 1'b0) begin err++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        vec++; if (mem_sel !== 4'h0) begin err++; $display("FAIL reset_mem_sel got %h exp 0", mem_sel); end
        vec++; if (mem_addr !== 32'h0) begin err++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        vec++; if (mem_wdata !== 32'h0) begin err++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        vec++; if ({instr_ack, dr_ack, dw_ack} !== 3'b000) begin err++; $display("FAIL reset_acks got %b exp 000", {instr_ack, dr_ack, dw_ack}); end
        reset = 1'b0;
    endtask

    task automatic test_single_instr();
        do_reset();
        instr_re = 1'b1; instr_addr = 32'h100; instr_sel = 4'hF;
        tick();   // cycle 1
        vec++; if (mem_re !== 1'b1) begin err++; $display("FAIL single_mem_re got %b exp 1", mem_re); end
        vec++; if (mem_addr !== 32'h100) begin err++; $display("FAIL single_mem_addr got %h exp 100", mem_addr); end
        vec++; if (mem_sel !== 4'hF) begin err++; $display("FAIL single_mem_sel got %h exp f", mem_sel); end
        vec++; if (instr_ack !== 1'b1) begin err++; $display("FAIL single_ack got %b exp 1", instr_ack); end
        vec++; if (instr_data !== (32'h100 ^ PAT)) begin err++; $display("FAIL single_data got %h exp %h", instr_data, 32'h100 ^ PAT); end
        instr_re = 1'b0;
        tick();   // cycle 2
        vec++; if (mem_re !== 1'b0) begin err++; $display("FAIL single_drop got %b exp 0", mem_re); end
        vec++; if (instr_ack !== 1'b0) begin err++; $display("FAIL single_ack_drop got %b exp 0", instr_ack); end
        tick();
        vec++; if (mem_re !== 1'b0) begin err++; $display("FAIL single_no_reissue got %b exp 0", mem_re); end
    endtask

    task automatic test_round_robin();
        do_reset();
        instr_re = 1'b1; instr_addr = 32'h200; instr_sel = 4'hF;
        dr_re = 1'b1; dr_addr = 32'h300; dr_sel = 4'h3;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c % 2 == 1) begin
                logic exp_i;
                exp_i = ((c % 4) == 1);
                vec++; if (mem_re !== 1'b1) begin err++; $display("FAIL rr_mem_re c%0d got %b exp 1", c, mem_re); end
                vec++; if (instr_ack !== exp_i || dr_ack !== ~exp_i) begin err++; $display("FAIL rr_owner c%0d got i=%b d=%b exp i=%b", c, instr_ack, dr_ack, exp_i); end
                vec++; if (mem_addr !== (exp_i ? 32'h200 : 32'h300)) begin err++; $display("FAIL rr_addr c%0d got %h", c, mem_addr); end
            end else begin
                vec++; if (mem_re !== 1'b0) begin err++; $display("FAIL rr_gap c%0d got %b exp 0", c, mem_re); end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_priority();
        do_reset();
        dw_we = 1'b1; dw_addr = 32'h40; dw_data = 32'hDEAD_BEEF; dw_sel = 4'hF;
        dr_re = 1'b1; dr_addr = 32'h40; dr_sel = 4'hF;
        tick();   // cycle 1: write
        vec++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin err++; $display("FAIL wp_write_strobe got we=%b re=%b exp we=1 re=0", mem_we, mem_re); end
        vec++; if (mem_wdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL wp_wdata got %h exp deadbeef", mem_wdata); end
        vec++; if (mem_addr !== 32'h40 || mem_sel !== 4'hF) begin err++; $display("FAIL wp_waddr got %h/%h exp 40/f", mem_addr, mem_sel); end
        vec++; if (dw_ack !== 1'b1 || dr_ack !== 1'b0) begin err++; $display("FAIL wp_wack got dw=%b dr=%b exp dw=1 dr=0", dw_ack, dr_ack); end
        dw_we = 1'b0;
        tick();   // cycle 2
        vec++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin err++; $display("FAIL wp_gap got we=%b re=%b exp 0", mem_we, mem_re); end
        tick();   // cycle 3: read
        vec++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin err++; $display("FAIL wp_read_strobe got re=%b we=%b exp re=1 we=0", mem_re, mem_we); end
        vec++; if (dr_ack !== 1'b1 || dw_ack !== 1'b0) begin err++; $display("FAIL wp_rack got dr=%b dw=%b exp dr=1 dw=0", dr_ack, dw_ack); end
        vec++; if (dr_data !== (32'h40 ^ PAT)) begin err++; $display("FAIL wp_rdata got %h exp %h", dr_data, 32'h40 ^ PAT); end
        dr_re = 1'b0;
        tick();
        vec++; if (overlap !== 0) begin err++; $display("FAIL wp_overlap got %0d exp 0", overlap); end
    endtask

    task automatic test_wait_states();
        int acks;
        do_reset();
        waits = 3;
        acks = 0;
        dr_re = 1'b1; dr_addr = 32'h80; dr_sel = 4'hC;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (dr_ack) acks++;
            if (c <= 4) begin
                vec++; if (mem_re !== 1'b1 || mem_addr !== 32'h80) begin err++; $display("FAIL ws_hold c%0d got re=%b addr=%h", c, mem_re, mem_addr); end
                vec++; if (dr_ack !== (c == 4)) begin err++; $display("FAIL ws_ack c%0d got %b exp %b", c, dr_ack, (c == 4)); end
            end else begin
                vec++; if (mem_re !== 1'b0) begin err++; $display("FAIL ws_drop c%0d got %b exp 0", c, mem_re); end
            end
            vec++; if (instr_ack !== 1'b0 || dw_ack !== 1'b0) begin err++; $display("FAIL ws_other c%0d got i=%b w=%b exp 0", c, instr_ack, dw_ack); end
            if (c == 4) dr_re = 1'b0;
        end
        vec++; if (acks !== 1) begin err++; $display("FAIL ws_ack_count got %0d exp 1", acks); end
        waits = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_block = 1'b1;
        dr_re = 1'b1; dr_addr = 32'h60; dr_sel = 4'hF;
        tick();   // cycle 1: BUSY, memory stalled
        vec++; if (mem_re !== 1'b1) begin err++; $display("FAIL rm_busy got %b exp 1", mem_re); end
        reset = 1'b1;
        tick();   // cycle 2: reset taken
        reset = 1'b0;
        vec++; if ({mem_re, mem_we} !== 2'b00 || mem_addr !== 32'h0 || mem_sel !== 4'h0 || mem_wdata !== 32'h0) begin err++; $display("FAIL rm_outputs got re=%b we=%b addr=%h", mem_re, mem_we, mem_addr); end
        stray_ack = 1'b1;
        ack_block = 1'b0;
        instr_re = 1'b1; instr_addr = 32'h500; instr_sel = 4'hF;
        #1;
        vec++; if ({instr_ack, dr_ack, dw_ack} !== 3'b000) begin err++; $display("FAIL rm_late_ack got %b exp 000", {instr_ack, dr_ack, dw_ack}); end
        tick();   // cycle 3: tie granted to instruction
        stray_ack = 1'b0;
        #1;
        vec++; if (mem_re !== 1'b1 || mem_addr !== 32'h500) begin err++; $display("FAIL rm_first_grant got re=%b addr=%h exp 1/500", mem_re, mem_addr); end
        vec++; if (instr_ack !== 1'b1 || dr_ack !== 1'b0) begin err++; $display("FAIL rm_first_owner got i=%b d=%b exp i=1 d=0", instr_ack, dr_ack); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_stray_ack();
        do_reset();
        stray_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vec++; if ({instr_ack, dr_ack, dw_ack} !== 3'b000 || {mem_re, mem_we} !== 2'b00) begin err++; $display("FAIL stray c%0d got acks=%b strobes=%b exp 0", c, {instr_ack, dr_ack, dw_ack}, {mem_re, mem_we}); end
        end
        stray_ack = 1'b0;
        dw_we = 1'b1; dw_addr = 32'h24; dw_data = 32'h1234_5678; dw_sel = 4'h1;
        tick();
        vec++; if (mem_we !== 1'b1 || dw_ack !== 1'b1 || mem_addr !== 32'h24) begin err++; $display("FAIL stray_after got we=%b ack=%b addr=%h", mem_we, dw_ack, mem_addr); end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_instr();
        test_round_robin();
        test_write_priority();
        test_wait_states();
        test_reset_mid();
        test_stray_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
